systolic_array_param: RTL and testbench

SYSTOLIC_ARRAY_PARAM -- requirements
Module: systolic_array_param

---
 rtl/systolic_array_param.sv | 193 +++++++++++++++++++
 tb/tb_systolic_array_param.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_param.sv
// Output-stationary N x N systolic multiplier: result = A*B, optionally added onto the held result.
// A rows stream east and B columns stream south, each skewed by row/column index.
module systolic_array_param #(
   parameter int ARRAY_SIZE        = 64,
   parameter int DATA_WIDTH        = 16,
   parameter int WEIGHT_WIDTH      = 8,
   parameter int ACCUMULATOR_WIDTH = 32
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                start,
   input  logic                                                signed_mode,
   input  logic                                                accumulate,
   input  logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]        matrix_a_flat,
   input  logic [WEIGHT_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]      matrix_b_flat,
   output logic [ACCUMULATOR_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] result_flat,
   output logic                                                busy,
   output logic                                                computation_done,
   output logic                                                result_valid
);
   localparam int N  = ARRAY_SIZE;
   localparam int DW = DATA_WIDTH;
   localparam int WW = WEIGHT_WIDTH;
   localparam int AW = ACCUMULATOR_WIDTH;
   localparam int PW = DW + WW;
   localparam int EW = (AW > PW) ? AW : PW;
   localparam int CW = $clog2(3 * N);
   localparam int IW = $clog2(N);
   localparam logic [CW-1:0] LAST_T = CW'(3 * N - 2);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_done;
   logic          r_valid;
   logic          r_cap_signed;
   logic          r_cap_acc;
   logic [DW-1:0] r_cap_a [N][N];
   logic [WW-1:0] r_cap_b [N][N];

   logic          w_accept;
   logic          w_load;
   logic          w_comp;
   logic          w_fin;
   logic [DW-1:0] w_a_west  [N];
   logic [WW-1:0] w_b_north [N];
   logic [DW-1:0] w_a_link  [N][N-1];
   logic [WW-1:0] w_b_link  [N-1][N];

   assign w_accept         = (r_state == S_IDLE) && start;
   assign w_load           = (r_state == S_LOAD);
   assign w_comp           = (r_state == S_COMPUTE);
   assign w_fin            = w_comp && (r_cnt == LAST_T);
   assign busy             = r_busy;
   assign computation_done = r_done;
   assign result_valid     = r_valid;

   // COMPUTE runs t = 0..3N-2; the last step adds only zeros, which puts the done pulse 3N edges after acceptance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_valid      <= 1'b0;
         r_cap_signed <= 1'b0;
         r_cap_acc    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state      <= S_LOAD;
                  r_busy       <= 1'b1;
                  r_valid      <= 1'b0;
                  r_cap_signed <= signed_mode;
                  r_cap_acc    <= accumulate;
               end
            end
            S_LOAD: begin
               r_state <= S_COMPUTE;
               r_cnt   <= '0;
            end
            S_COMPUTE: begin
               if (r_cnt == LAST_T) begin
                  r_state <= S_DONE;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
                  r_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               r_cap_a[i][j] <= '0;
               r_cap_b[i][j] <= '0;
            end
         end
      end else if (w_accept) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               r_cap_a[i][j] <= matrix_a_flat[(i*N+j)*DW +: DW];
               r_cap_b[i][j] <= matrix_b_flat[(i*N+j)*WW +: WW];
            end
         end
      end
   end

   // Edge feeders: row i sees A[i][t-i], column j sees B[t-j][j], zero outside the valid window.
   for (genvar e = 0; e < N; e++) begin : g_edge
      logic [CW-1:0] w_k;
      assign w_k = r_cnt - CW'(e);
      assign w_a_west[e]  = (w_comp && (r_cnt >= CW'(e)) && (w_k < CW'(N))) ? r_cap_a[e][w_k[IW-1:0]] : '0;
      assign w_b_north[e] = (w_comp && (r_cnt >= CW'(e)) && (w_k < CW'(N))) ? r_cap_b[w_k[IW-1:0]][e] : '0;
   end

   for (genvar i = 0; i < N; i++) begin : g_r
      for (genvar j = 0; j < N; j++) begin : g_c
         logic [DW-1:0] w_a_in;
         logic [WW-1:0] w_b_in;
         logic [PW-1:0] w_ax;
         logic [PW-1:0] w_bx;
         logic [PW-1:0] w_prod;
         logic [EW-1:0] w_ext;
         logic [AW-1:0] w_acc_next;
         logic [AW-1:0] r_acc;
         logic [AW-1:0] r_res;

         if (j == 0) begin : g_aw
            assign w_a_in = w_a_west[i];
         end else begin : g_al
            assign w_a_in = w_a_link[i][j-1];
         end
         if (i == 0) begin : g_bn
            assign w_b_in = w_b_north[j];
         end else begin : g_bl
            assign w_b_in = w_b_link[i-1][j];
         end

         if (j < N - 1) begin : g_ap
            logic [DW-1:0] r_a;
            always_ff @(posedge clk) begin
               if (!rst_n || w_load) r_a <= '0;
               else if (w_comp)      r_a <= w_a_in;
            end
            assign w_a_link[i][j] = r_a;
         end
         if (i < N - 1) begin : g_bp
            logic [WW-1:0] r_b;
            always_ff @(posedge clk) begin
               if (!rst_n || w_load) r_b <= '0;
               else if (w_comp)      r_b <= w_b_in;
            end
            assign w_b_link[i][j] = r_b;
         end

         // Low PW bits of the product of extended operands equal the exact signed or unsigned product.
         assign w_ax       = r_cap_signed ? {{WW{w_a_in[DW-1]}}, w_a_in} : {{WW{1'b0}}, w_a_in};
         assign w_bx       = r_cap_signed ? {{DW{w_b_in[WW-1]}}, w_b_in} : {{DW{1'b0}}, w_b_in};
         assign w_prod     = w_ax * w_bx;
         assign w_ext      = r_cap_signed ? EW'($signed(w_prod)) : EW'(w_prod);
         assign w_acc_next = r_acc + w_ext[AW-1:0];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_acc <= '0;
               r_res <= '0;
            end else if (w_load) begin
               r_acc <= r_cap_acc ? r_res : '0;
            end else if (w_comp) begin
               r_acc <= w_acc_next;
               if (w_fin) r_res <= w_acc_next;
            end
         end

         assign result_flat[(i*N+j)*AW +: AW] = r_res;
      end
   end
endmodule

// File: tb/tb_systolic_array_param.sv
// Directed and randomized bench for systolic_array_param at N=4, plus the N=64 identity/corner checks.
module tb_systolic_array_param;
   localparam int BIG = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic          start4, sm4, ac4;
   logic [255:0]  a4;
   logic [127:0]  b4;
   logic [511:0]  res4;
   logic          busy4, done4, valid4;

   logic                   start64;
   logic [16*BIG*BIG-1:0]  a64;
   logic [8*BIG*BIG-1:0]   b64;
   logic [32*BIG*BIG-1:0]  res64;
   logic                   busy64, done64, valid64;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] ma    [4][4];
   logic [7:0]  mb    [4][4];
   logic [31:0] exp_c [4][4];

   systolic_array_param #(.ARRAY_SIZE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4), .accumulate(ac4),
      .matrix_a_flat(a4), .matrix_b_flat(b4), .result_flat(res4),
      .busy(busy4), .computation_done(done4), .result_valid(valid4));

   systolic_array_param #(.ARRAY_SIZE(BIG)) dut64 (
      .clk(clk), .rst_n(rst_n), .start(start64), .signed_mode(1'b0), .accumulate(1'b0),
      .matrix_a_flat(a64), .matrix_b_flat(b64), .result_flat(res64),
      .busy(busy64), .computation_done(done64), .result_valid(valid64));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Plain matrix product mod 2^32, operands interpreted per signed_mode.
   task automatic model_job(input logic sm, input logic ac);
      longint av, bv;
      logic [31:0] s;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            s = ac ? exp_c[i][j] : 32'd0;
            for (int k = 0; k < 4; k++) begin
               av = sm ? longint'($signed(ma[i][k])) : longint'(ma[i][k]);
               bv = sm ? longint'($signed(mb[k][j])) : longint'(mb[k][j]);
               s  = s + 32'(av * bv);
            end
            exp_c[i][j] = s;
         end
      end
   endtask

   task automatic pack4();
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            a4[(i*4+j)*16 +: 16] = ma[i][j];
            b4[(i*4+j)*8 +: 8]   = mb[i][j];
         end
      end
   endtask

   function automatic logic [511:0] pack_exp();
      logic [511:0] v;
      v = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            v[(i*4+j)*32 +: 32] = exp_c[i][j];
      return v;
   endfunction

   task automatic fill_a_identity();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            ma[i][j] = (i == j) ? 16'd1 : 16'd0;
   endtask

   task automatic fill_b_const(input logic [7:0] v);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            mb[i][j] = v;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            ma[i][j] = 16'($urandom());
            mb[i][j] = 8'($urandom_range(0, 255));
         end
      end
   endtask

   // Counts negedges until done is seen; hold drops if the result moves or valid rises early.
   task automatic wait_done4(output int lat, output bit hold, input logic [511:0] prev);
      hold = 1'b1;
      for (lat = 1; lat <= 100; lat++) begin
         @(negedge clk);
         if (done4) break;
         if (res4 !== prev || valid4 !== 1'b0) hold = 1'b0;
      end
   endtask

   task automatic run_job4(input string tag, input logic sm, input logic ac);
      int lat;
      bit hold;
      logic [511:0] prev;
      prev = pack_exp();
      pack4();
      @(negedge clk);
      sm4 = sm; ac4 = ac; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      model_job(sm, ac);
      for (int w = 0; w < 8; w++) a4[w*32 +: 32] = $urandom();
      for (int w = 0; w < 4; w++) b4[w*32 +: 32] = $urandom();
      sm4 = ~sm; ac4 = ~ac;
      check({tag, ":valid_cleared"}, valid4, 1'b0);
      check({tag, ":busy"}, busy4, 1'b1);
      wait_done4(lat, hold, prev);
      check({tag, ":latency"}, lat, 12);
      check({tag, ":hold_until_done"}, hold, 1'b1);
      check({tag, ":result"}, res4, pack_exp());
      check({tag, ":valid"}, valid4, 1'b1);
      @(negedge clk);
      check({tag, ":done_one_cycle"}, done4, 1'b0);
   endtask

   task automatic run_job64(input string tag, input bit first_row_only);
      int lat, errs;
      logic [31:0] e;
      @(negedge clk);
      start64 = 1'b1;
      @(negedge clk);
      start64 = 1'b0;
      for (lat = 1; lat <= 400; lat++) begin
         @(negedge clk);
         if (done64) break;
      end
      check({tag, ":latency"}, lat, 192);
      errs = 0;
      for (int i = 0; i < BIG; i++) begin
         for (int j = 0; j < BIG; j++) begin
            e = (!first_row_only || i == 0) ? 32'd1 : 32'd0;
            if (res64[(i*BIG+j)*32 +: 32] !== e) errs++;
         end
      end
      check({tag, ":bad_elements"}, errs, 0);
      check({tag, ":valid"}, valid64, 1'b1);
      @(negedge clk);
      check({tag, ":idle"}, busy64, 1'b0);
   endtask

   initial begin
      int lat, n_done, n_busy;
      bit hold;
      logic [511:0] prev;

      rst_n = 1'b0; start4 = 1'b0; sm4 = 1'b0; ac4 = 1'b0; a4 = '0; b4 = '0;
      start64 = 1'b0; a64 = '0; b64 = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            exp_c[i][j] = 32'd0;
      repeat (3) @(negedge clk);
      check("reset:busy", busy4, 1'b0);
      check("reset:done", done4, 1'b0);
      check("reset:valid", valid4, 1'b0);
      check("reset:result", res4, '0);
      rst_n = 1'b1;

      fill_a_identity();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            mb[i][j] = 8'(i * 4 + j);
      run_job4("ident_b_index", 1'b0, 1'b0);
      check("ident_b_index:c23", res4[(2*4+3)*32 +: 32], 32'd11);

      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            ma[i][j] = 16'hFFFF;
      fill_b_const(8'h02);
      run_job4("neg_signed", 1'b1, 1'b0);
      check("neg_signed:c00", res4[31:0], 32'hFFFF_FFF8);
      run_job4("neg_unsigned", 1'b0, 1'b0);
      check("neg_unsigned:c33", res4[511:480], 32'h0007_FFF8);

      fill_a_identity();
      fill_b_const(8'd3);
      run_job4("acc_first", 1'b0, 1'b0);
      check("acc_first:c12", res4[(1*4+2)*32 +: 32], 32'd3);
      run_job4("acc_second", 1'b0, 1'b1);
      check("acc_second:c31", res4[(3*4+1)*32 +: 32], 32'd6);

      // Start pulses in COMPUTE and in the DONE cycle must be dropped.
      fill_random();
      pack4();
      @(negedge clk);
      sm4 = 1'b1; ac4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      model_job(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      wait_done4(lat, hold, res4);
      check("ignore:latency", lat, 8);
      check("ignore:result", res4, pack_exp());
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      check("ignore:idle_after_done", busy4, 1'b0);
      n_done = 0; n_busy = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done4) n_done++;
         if (busy4) n_busy++;
      end
      check("ignore:no_extra_done", n_done, 0);
      check("ignore:no_extra_busy", n_busy, 0);

      // Start held high: back-to-back jobs with a single IDLE cycle between them.
      fill_a_identity();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            mb[i][j] = 8'($urandom_range(0, 255));
      pack4();
      prev = pack_exp();
      @(negedge clk);
      sm4 = 1'b0; ac4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      model_job(1'b0, 1'b0);
      wait_done4(lat, hold, prev);
      check("held:first_latency", lat, 12);
      check("held:first_result", res4, pack_exp());
      @(negedge clk);
      check("held:idle_gap", busy4, 1'b0);
      @(negedge clk);
      check("held:reaccepted", busy4, 1'b1);
      check("held:valid_cleared", valid4, 1'b0);
      start4 = 1'b0;
      wait_done4(lat, hold, res4);
      check("held:second_latency", lat, 12);
      check("held:second_result", res4, pack_exp());
      @(negedge clk);

      // Reset during COMPUTE at t=5 aborts the job cleanly.
      fill_random();
      pack4();
      @(negedge clk);
      sm4 = 1'b1; ac4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort:busy", busy4, 1'b0);
      check("abort:done", done4, 1'b0);
      check("abort:valid", valid4, 1'b0);
      check("abort:result", res4, '0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            exp_c[i][j] = 32'd0;
      n_done = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (done4) n_done++;
      end
      check("abort:no_done", n_done, 0);
      fill_random();
      run_job4("after_abort", 1'b1, 1'b1);

      for (int r = 0; r < 6; r++) begin
         fill_random();
         run_job4($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      a64 = '0;
      a64[15:0] = 16'd1;
      for (int e = 0; e < BIG*BIG; e++) b64[e*8 +: 8] = 8'd1;
      run_job64("n64_a00", 1'b1);
      a64 = '0;
      for (int i = 0; i < BIG; i++) a64[(i*BIG+i)*16 +: 16] = 16'd1;
      run_job64("n64_ident", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
